ws2812b_strip_ctrl: RTL and testbench

Frame sequencer for a chain of WS2812B LEDs. It holds an on-chip pixel buffer and streams it, pixel by pixel, into the existing single-pixel WS2812B driver over that driver's en/busy handshake. After the last pixel it holds the line idle for the latch/reset gap. It sits between user logic, which writes colours and requests frames, and the pixel driver, which owns the serial line.

---
 rtl/ws2812b_strip_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ws2812b_strip_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_strip_ctrl.sv
// ws2812b_strip_ctrl
// Frame sequencer for a WS2812B chain. It streams an on-chip pixel buffer, one
// pixel at a time, into the single-pixel driver over its en/busy handshake,
// then holds the line idle for the latch gap before reporting frame_done.
//
// Build macro WS2812B_AUTO_REFRESH_EN adds REFRESH_CYCLES and the auto_en
// input. Frames then re-trigger themselves periodically while auto_en is high.
//
// state | meaning
// IDLE  | waiting for a frame request
// LOAD  | buffer read of the current pixel issued
// SEND  | px_en pulse, colour outputs carry the pixel
// ACK   | waiting (bounded) for the driver to raise busy
// WAIT  | driver is shifting the pixel out
// LATCH | line held low for the latch/reset gap
// DONE  | one-cycle frame_done, then back to IDLE
module ws2812b_strip_ctrl #(
    parameter int LED_NUM        = 8,
    parameter int ADDR_W         = 8,
    parameter int LATCH_CYCLES   = 8100,
    parameter int ACK_TIMEOUT    = 4
`ifdef WS2812B_AUTO_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 900000
`endif
) (
    input  logic              Clock,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_rgb,
    input  logic              start,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              err_timeout,
    output logic              px_en,
    output logic [7:0]        px_red,
    output logic [7:0]        px_green,
    output logic [7:0]        px_blue,
`ifdef WS2812B_AUTO_REFRESH_EN
    input  logic              auto_en,
`endif
    input  logic              px_busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_LATCH = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // Buffer index width: just enough bits to address LED_NUM entries.
    localparam int IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    // One extra bit so LED_NUM = 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   LED_NUM_X = (ADDR_W+1)'(LED_NUM);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LED_NUM - 1);

    logic [23:0]       mem [0:LED_NUM-1];
    logic [23:0]       rd_q;
    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ACK_W-1:0]  ack_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              start_req;
    logic              frame_start;

`ifdef WS2812B_AUTO_REFRESH_EN
    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    logic [REF_W-1:0] ref_cnt;

    // Refresh timer: reloads at every frame start, saturates at zero meaning "due".
    always_ff @(posedge Clock or posedge rst) begin
        if (rst)
            ref_cnt <= '0;
        else if (frame_start)
            ref_cnt <= REF_W'(REFRESH_CYCLES - 1);
        else if (ref_cnt != '0)
            ref_cnt <= ref_cnt - 1'b1;
    end

    assign start_req = start || (auto_en && (ref_cnt == '0));
`else
    assign start_req = start;
`endif

    assign frame_start = (state == S_IDLE) && start_req;

    // Pixel buffer write port; out-of-range indices are dropped, contents survive reset.
    always_ff @(posedge Clock) begin
        if (wr_en && ({1'b0, wr_addr} < LED_NUM_X))
            mem[wr_addr[IDX_W-1:0]] <= wr_rgb;
    end

    // Registered read in LOAD; a same-cycle write to that index is not seen until later.
    always_ff @(posedge Clock or posedge rst) begin
        if (rst)
            rd_q <= '0;
        else if (state == S_LOAD)
            rd_q <= mem[idx[IDX_W-1:0]];
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_req) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SEND;
            S_SEND:  state_nxt = S_ACK;
            S_ACK: begin
                if (px_busy)
                    state_nxt = S_WAIT;
                else if (ack_cnt == '0)
                    state_nxt = S_LATCH;
            end
            S_WAIT: begin
                if (!px_busy)
                    state_nxt = (idx == LAST_IDX) ? S_LATCH : S_LOAD;
            end
            S_LATCH: if (lat_cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register plus index, ack timer and sticky timeout flag.
    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            ack_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        idx         <= '0;
                        err_timeout <= 1'b0;
                    end
                end
                S_SEND: ack_cnt <= ACK_W'(ACK_TIMEOUT - 1);
                S_ACK: begin
                    if (!px_busy) begin
                        if (ack_cnt == '0)
                            err_timeout <= 1'b1;
                        else
                            ack_cnt <= ack_cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!px_busy && (idx != LAST_IDX))
                        idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Latch-gap down-counter: loaded on entry so LATCH lasts exactly LATCH_CYCLES cycles.
    always_ff @(posedge Clock or posedge rst) begin
        if (rst)
            lat_cnt <= '0;
        else if ((state != S_LATCH) && (state_nxt == S_LATCH))
            lat_cnt <= LAT_W'(LATCH_CYCLES - 1);
        else if ((state == S_LATCH) && (lat_cnt != '0))
            lat_cnt <= lat_cnt - 1'b1;
    end

    assign px_en      = (state == S_SEND);
    assign frame_done = (state == S_DONE);
    assign frame_busy = (state != S_IDLE) && (state != S_DONE);
    assign px_red     = rd_q[23:16];
    assign px_green   = rd_q[15:8];
    assign px_blue    = rd_q[7:0];

endmodule

// File: tb/tb_ws2812b_strip_ctrl.sv
// tb_ws2812b_strip_ctrl
// Directed bench for ws2812b_strip_ctrl with a 3-LED chain and a simple
// driver model that raises busy the cycle after px_en for BUSY_LEN cycles.
// Optional section runs when WS2812B_AUTO_REFRESH_EN is defined.
module tb_ws2812b_strip_ctrl;

    localparam int LATCH    = 20;
    localparam int ACK_TO   = 4;
    localparam int BUSY_LEN = 5;
`ifdef WS2812B_AUTO_REFRESH_EN
    localparam int REFRESH  = 300;
    logic auto_en = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [23:0] wr_rgb;
    logic        start;
    logic        frame_busy;
    logic        frame_done;
    logic        err_timeout;
    logic        px_en;
    logic [7:0]  px_red;
    logic [7:0]  px_green;
    logic [7:0]  px_blue;
    logic        px_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ws2812b_strip_ctrl #(
        .LED_NUM(3),
        .ADDR_W(4),
        .LATCH_CYCLES(LATCH),
        .ACK_TIMEOUT(ACK_TO)
`ifdef WS2812B_AUTO_REFRESH_EN
        ,
        .REFRESH_CYCLES(REFRESH)
`endif
    ) dut (
        .Clock(Clock),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_rgb(wr_rgb),
        .start(start),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .err_timeout(err_timeout),
        .px_en(px_en),
        .px_red(px_red),
        .px_green(px_green),
        .px_blue(px_blue),
`ifdef WS2812B_AUTO_REFRESH_EN
        .auto_en(auto_en),
`endif
        .px_busy(px_busy)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Driver model; drv_on = 0 emulates a driver that never acknowledges.
    logic drv_on = 1'b1;
    int   busy_cnt = 0;
    always @(posedge Clock) begin
        if (drv_on && px_en)
            busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign px_busy = (busy_cnt != 0);

    // Monitor: records pixels sent and event cycles, sampled on the falling edge.
    logic [23:0] px_q[$];
    int first_en_cyc = 0, last_en_cyc = 0, fall_cyc = 0, done_cyc = 0, err_cyc = 0;
    int done_cnt = 0;
    logic busy_prev = 1'b0, err_prev = 1'b0;
    always @(negedge Clock) begin
        if (px_en) begin
            if (px_q.size() == 0) first_en_cyc = cyc;
            last_en_cyc = cyc;
            px_q.push_back({px_red, px_green, px_blue});
        end
        if (busy_prev && !px_busy) fall_cyc = cyc;
        busy_prev = px_busy;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err_timeout && !err_prev) err_cyc = cyc;
        err_prev = err_timeout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_rgb  = d;
        @(negedge Clock);
        wr_en   = 1'b0;
    endtask

    // Pulses start for one cycle; acc is the cycle in which start is sampled.
    task automatic start_frame(output int acc);
        start = 1'b1;
        acc   = cyc;
        @(negedge Clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge Clock);
            if (frame_done) seen = 1'b1;
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
        @(negedge Clock);
    endtask

    task automatic clear_mon();
        px_q.delete();
        done_cnt = 0;
    endtask

    int acc;
    int n;

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_rgb  = '0;
        start   = 1'b0;
        repeat (2) @(negedge Clock);
        chk("reset_ctrl", {28'd0, frame_busy, frame_done, err_timeout, px_en}, 32'd0);
        chk("reset_rgb", {8'd0, px_red, px_green, px_blue}, 32'd0);
        rst = 1'b0;
        @(negedge Clock);

        wr(4'd0, 24'hFF0000);
        wr(4'd1, 24'h00FF00);
        wr(4'd2, 24'h0000FF);

        // Basic frame: three pixels, two-cycle start latency, latch gap.
        clear_mon();
        start_frame(acc);
        chk("busy_after_start", {31'd0, frame_busy}, 32'd1);
        wait_done(400);
        chk("start_latency", first_en_cyc - acc, 32'd2);
        chk("f1_px_count", px_q.size(), 32'd3);
        chk("f1_px0", {8'd0, px_q[0]}, 32'hFF0000);
        chk("f1_px1", {8'd0, px_q[1]}, 32'h00FF00);
        chk("f1_px2", {8'd0, px_q[2]}, 32'h0000FF);
        // WAIT sees busy low, then LATCH spans LATCH cycles, then DONE.
        chk("latch_gap", done_cyc - fall_cyc, 32'(LATCH + 1));
        chk("idle_after_done", {30'd0, frame_busy, frame_done}, 32'd0);

        // Driver never acknowledges: timeout, abandon, still finish.
        drv_on = 1'b0;
        clear_mon();
        start_frame(acc);
        wait_done(400);
        chk("to_px_count", px_q.size(), 32'd1);
        chk("to_latency", err_cyc - last_en_cyc, 32'(ACK_TO + 1));
        chk("to_sticky", {31'd0, err_timeout}, 32'd1);
        chk("to_done_cnt", done_cnt, 32'd1);
        drv_on = 1'b1;

        // Accepted start clears the flag; mid-frame write and start.
        clear_mon();
        start_frame(acc);
        chk("err_cleared", {31'd0, err_timeout}, 32'd0);
        wr(4'd2, 24'h123456);
        repeat (3) @(negedge Clock);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        wait_done(400);
        repeat (10) @(negedge Clock);
        chk("mid_px_count", px_q.size(), 32'd3);
        chk("mid_px0", {8'd0, px_q[0]}, 32'hFF0000);
        chk("mid_px2", {8'd0, px_q[2]}, 32'h123456);
        chk("mid_done_cnt", done_cnt, 32'd1);

        // Out-of-range write must not touch the buffer.
        wr(4'd2, 24'h0000FF);
        wr(4'd5, 24'h00ABCD);
        clear_mon();
        start_frame(acc);
        wait_done(400);
        chk("oor_px0", {8'd0, px_q[0]}, 32'hFF0000);
        chk("oor_px1", {8'd0, px_q[1]}, 32'h00FF00);
        chk("oor_px2", {8'd0, px_q[2]}, 32'h0000FF);

        // Reset while in WAIT for pixel 1.
        start_frame(acc);
        n = 0;
        for (int i = 0; i < 200 && n < 2; i++) begin
            @(negedge Clock);
            if (px_en) n++;
        end
        chk("rst_px1_seen", n, 32'd2);
        repeat (2) @(negedge Clock);
        chk("rst_busy_before", {31'd0, frame_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_busy_after", {31'd0, frame_busy}, 32'd0);
        chk("rst_px_en_after", {31'd0, px_en}, 32'd0);
        @(negedge Clock);
        rst = 1'b0;
        for (int i = 0; i < 20 && px_busy; i++) @(negedge Clock);
        clear_mon();
        start_frame(acc);
        wait_done(400);
        chk("rst_restart_count", px_q.size(), 32'd3);
        chk("rst_restart_px0", {8'd0, px_q[0]}, 32'hFF0000);

`ifdef WS2812B_AUTO_REFRESH_EN
        begin
            int rises, r_prev, r_last;
            logic fbp;
            rises = 0; r_prev = 0; r_last = 0; fbp = frame_busy;
            auto_en = 1'b1;
            for (int i = 0; i < 1500 && rises < 3; i++) begin
                @(negedge Clock);
                if (frame_busy && !fbp) begin
                    rises++;
                    r_prev = r_last;
                    r_last = cyc;
                end
                fbp = frame_busy;
            end
            chk("auto_rises", rises, 32'd3);
            chk("auto_period", r_last - r_prev, 32'(REFRESH));
            auto_en = 1'b0;
            rises = 0;
            for (int i = 0; i < 2 * REFRESH; i++) begin
                @(negedge Clock);
                if (frame_busy && !fbp) rises++;
                fbp = frame_busy;
            end
            chk("auto_stopped", rises, 32'd0);
            chk("auto_idle", {31'd0, frame_busy}, 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
